stream_serializer: RTL
======================

// Module: stream_serializer
// PURPOSE
//  Parametrised wide-to-narrow serializer with valid/ready handshake on both sides.
//  Converts IN_WIDTH frames (e.g. 8-point FFT result vectors) into OUT_WIDTH words.
//  Per-frame word count and word order. Two-deep frame buffer, so back-to-back frames
//  stream with no bubble. Sits between the FFT core output and the narrow result bus.
// PARAMETERS
//  IN_WIDTH   256  frame width in bits; must be an integer multiple of OUT_WIDTH
//  OUT_WIDTH  16   output word width in bits
//  NUM_WORDS  IN_WIDTH/OUT_WIDTH (localparam); CNT_W = $clog2(NUM_WORDS) (localparam)
// PORTS
//  clk        in   1          clock, all logic on rising edge
//  reset_n    in   1          synchronous, active-low reset
//  in_valid   in   1          frame offered on in_data/in_len/in_msb_first
//  in_ready   out  1          block can accept a frame this cycle
//  in_data    in   IN_WIDTH   frame payload
//  in_len     in   CNT_W      words to emit, 1..NUM_WORDS-1; 0 means NUM_WORDS
//  in_msb_first in 1          1: first word is in_data[IN_WIDTH-1 -: OUT_WIDTH]; 0: [OUT_WIDTH-1:0]
//  out_data   out  OUT_WIDTH  current word
//  out_valid  out  1          out_data/out_last valid
//  out_ready  in   1          sink accepts the word this cycle
//  out_last   out  1          current word is the final word of its frame
//  frame_done out  1          one-cycle pulse, cycle after final-word handshake
//  busy       out  1          active or holding frame present
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, out_last=0, frame_done=0, busy=0, in_ready=1; both buffers empty.
//  Reset mid-frame: both frames discarded, no frame_done, no further words.
//  Storage: ACTIVE shift register (frame being emitted) plus HOLD register (next frame).
//  in_ready is registered = !hold_full. Accept = in_valid & in_ready.
//  The accept samples in_data, in_len and in_msb_first together.
//  Accept with ACTIVE empty, or emptying this edge: frame loads directly into ACTIVE.
//  Otherwise the frame loads into HOLD.
//  Latency: frame accepted at edge N -> out_valid=1 with first word after edge N.
//  Advance on out_valid & out_ready only.
//  While out_valid & !out_ready, out_data and out_last hold stable (AXI-style).
//  Words emitted in order toward the LSB (msb_first=1) or toward the MSB (msb_first=0).
//  in_len<NUM_WORDS emits only the first in_len words in that order; remaining bits are dropped.
//  out_last=1 exactly on word index len-1. in_len=1 gives a single word with out_last=1.
//  Final-word handshake with HOLD full: HOLD moves to ACTIVE on the same edge.
//  out_valid stays 1 and in_ready rises the next cycle. No idle cycle.
//  Final-word handshake with HOLD empty and a simultaneous accept: the new frame goes to ACTIVE.
//  out_valid stays 1.
//  Final-word handshake, nothing pending: out_valid=0, out_last=0; out_data keeps its last value.
//  frame_done pulses 1 cycle after each final-word handshake. On consecutive frames it is never merged.
//  FSM ser_state_t: IDLE (ACTIVE empty) -> STREAM on accept.
//  STREAM -> IDLE on final handshake with no frame pending or arriving; otherwise STREAM.
//  Word counter is CNT_W+1 bits wide, compares against the effective length, never wraps past it.
//  busy = (state==STREAM) | hold_full.
// STRUCTURE
//  Package stream_ser_pkg: ser_state_t enum {IDLE, STREAM}; function eff_len(in_len) (0 -> NUM_WORDS).
//  Sub-module ser_frame_slot: one frame slot storing {data, len, msb_first} with load/valid flag.
//  Instantiated twice (ACTIVE, HOLD). Shift/select logic and FSM stay in the top.
// TESTING (IN_WIDTH=256, OUT_WIDTH=16)
//  1. Frame 0x0123..CDEF, in_len=0, msb_first=1, out_ready=1:
//     16 words 0x0123,0x4567,0x89AB,0xCDEF,... on consecutive cycles; last on word 16; frame_done 1 cycle later.
//  2. Same frame, msb_first=0, in_len=3: words 0xCDEF,0x89AB,0x4567; out_last on 3rd; frame_done once.
//  3. Backpressure: out_ready toggling 1,0,0,1,...
//     Each word is held stable while !out_ready; word count stays 16, with no duplicates or drops.
//  4. Two frames 0x0123.. and 0xFEDC.. offered back-to-back with out_ready=1:
//     32 words with no out_valid gap; in_ready=0 while HOLD is full; two frame_done pulses.
//  5. reset_n=0 for 1 cycle at word 5 with HOLD full: next cycle all outputs match reset values.
//     No frame_done. A fresh frame afterwards starts from word 0.
//  6. in_len=1 frame back-to-back with a full frame: single word with out_last=1, then 16 words. No bubble.

Source files
------------

// File: rtl/stream_ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_ser_pkg
//  Purpose  : Shared types and helpers for the wide-to-narrow stream
//             serializer (FSM state encoding, effective length decode).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package stream_ser_pkg;

    // Serializer control state: IDLE means the ACTIVE slot is empty.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

    // A length field of zero encodes a full frame of num_words words.
    function automatic int unsigned eff_len(input int unsigned len,
                                            input int unsigned num_words);
        return (len == 0) ? num_words : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ser_frame_slot.sv
`default_nettype none
// ============================================================================
//  Module   : ser_frame_slot
//  Purpose  : One frame storage slot holding {data, len, msb_first} and an
//             occupancy flag. The data field can be rewritten in place so the
//             same slot works as a shift register.
//  Ports    : clk, reset_n          clock / synchronous active-low reset
//             i_load                capture i_data/i_len/i_msb_first, set valid
//             i_clear               drop occupancy (data kept)
//             i_shift               replace data with i_shift_data
//             o_data/o_len/o_msb_first/o_valid   stored contents
//  Revision : 1.0  initial release
// ============================================================================
module ser_frame_slot #(
    parameter int DATA_W = 256,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_msb_first,
    input  logic [DATA_W-1:0] i_shift_data,
    output logic [DATA_W-1:0] o_data,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_msb_first,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_len;
    logic              r_msb_first;
    logic              r_valid;

    // Load wins over clear/shift: a slot emptying and refilling on the same
    // edge must end up holding the new frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_len       <= '0;
            r_msb_first <= 1'b0;
            r_valid     <= 1'b0;
        end else if (i_load) begin
            r_data      <= i_data;
            r_len       <= i_len;
            r_msb_first <= i_msb_first;
            r_valid     <= 1'b1;
        end else begin
            if (i_clear) begin
                r_valid <= 1'b0;
            end
            if (i_shift) begin
                r_data <= i_shift_data;
            end
        end
    end

    assign o_data      = r_data;
    assign o_len       = r_len;
    assign o_msb_first = r_msb_first;
    assign o_valid     = r_valid;

endmodule
`default_nettype wire

// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_serializer
//  Purpose  : Wide-to-narrow serializer with valid/ready on both sides.
//             IN_WIDTH frames are emitted as OUT_WIDTH words, per-frame word
//             count and order, with a two-deep (ACTIVE + HOLD) frame buffer
//             so consecutive frames stream without a bubble.
//  Ports    : clk, reset_n                    clock / sync active-low reset
//             in_valid, in_ready, in_data, in_len, in_msb_first   frame input
//             out_data, out_valid, out_ready, out_last            word output
//             frame_done                     pulse after final-word handshake
//             busy                           ACTIVE or HOLD occupied
//  Revision : 1.0  initial release
// ============================================================================
module stream_serializer
    import stream_ser_pkg::*;
#(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [IN_WIDTH-1:0]                        in_data,
    input  logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0]      in_len,
    input  logic                                       in_msb_first,
    output logic [OUT_WIDTH-1:0]                       out_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_last,
    output logic                                       frame_done,
    output logic                                       busy
);

    localparam int NUM_WORDS = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    ser_state_t          r_state;
    ser_state_t          w_state_next;

    logic [IN_WIDTH-1:0] w_act_data;
    logic [CNT_W-1:0]    w_act_len;
    logic                w_act_msb;
    logic                w_act_valid;

    logic [IN_WIDTH-1:0] w_hold_data;
    logic [CNT_W-1:0]    w_hold_len;
    logic                w_hold_msb;
    logic                w_hold_valid;

    logic [IN_WIDTH-1:0] w_act_src_data;
    logic [CNT_W-1:0]    w_act_src_len;
    logic                w_act_src_msb;
    logic [IN_WIDTH-1:0] w_act_shifted;

    logic [CNT_W:0]      r_cnt;
    logic [CNT_W:0]      w_eff_len;
    logic [CNT_W:0]      w_last_idx;

    logic                r_in_ready;
    logic                r_frame_done;

    logic                w_accept;
    logic                w_fire;
    logic                w_final;
    logic                w_act_free;
    logic                w_act_load;
    logic                w_act_clear;
    logic                w_act_shift;
    logic                w_hold_load;
    logic                w_hold_clear;
    logic                w_hold_valid_next;

    // ------------------------------------------------------------------
    // Handshake events
    // ------------------------------------------------------------------
    assign w_accept   = in_valid & r_in_ready;
    assign w_fire     = out_valid & out_ready;
    assign w_final    = w_fire & out_last;
    assign w_act_free = ~w_act_valid | w_final;

    // in_ready mirrors !HOLD occupancy, so an accept never coincides with a
    // full HOLD; a new frame goes straight to ACTIVE whenever it is free.
    assign w_hold_load  = w_accept & ~w_act_free;
    assign w_hold_clear = w_final & w_hold_valid;
    assign w_act_load   = w_hold_clear | (w_accept & w_act_free);
    assign w_act_clear  = w_final & ~w_act_load;
    // The final word never shifts so out_data keeps its last value when idle.
    assign w_act_shift  = w_fire & ~out_last;

    assign w_hold_valid_next = w_hold_load | (w_hold_valid & ~w_hold_clear);

    // ACTIVE refills from HOLD when one is waiting, else from the input port.
    assign w_act_src_data = w_hold_valid ? w_hold_data : in_data;
    assign w_act_src_len  = w_hold_valid ? w_hold_len  : in_len;
    assign w_act_src_msb  = w_hold_valid ? w_hold_msb  : in_msb_first;

    // The current word always sits at the end the frame starts from.
    assign w_act_shifted = w_act_msb ? (w_act_data << OUT_WIDTH)
                                     : (w_act_data >> OUT_WIDTH);

    // ------------------------------------------------------------------
    // Frame slots
    // ------------------------------------------------------------------
    ser_frame_slot #(
        .DATA_W (IN_WIDTH),
        .LEN_W  (CNT_W)
    ) u_active_slot (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_act_load),
        .i_clear      (w_act_clear),
        .i_shift      (w_act_shift),
        .i_data       (w_act_src_data),
        .i_len        (w_act_src_len),
        .i_msb_first  (w_act_src_msb),
        .i_shift_data (w_act_shifted),
        .o_data       (w_act_data),
        .o_len        (w_act_len),
        .o_msb_first  (w_act_msb),
        .o_valid      (w_act_valid)
    );

    ser_frame_slot #(
        .DATA_W (IN_WIDTH),
        .LEN_W  (CNT_W)
    ) u_hold_slot (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_hold_load),
        .i_clear      (w_hold_clear),
        .i_shift      (1'b0),
        .i_data       (in_data),
        .i_len        (in_len),
        .i_msb_first  (in_msb_first),
        .i_shift_data ({IN_WIDTH{1'b0}}),
        .o_data       (w_hold_data),
        .o_len        (w_hold_len),
        .o_msb_first  (w_hold_msb),
        .o_valid      (w_hold_valid)
    );

    // ------------------------------------------------------------------
    // Word counter: index of the word currently presented
    // ------------------------------------------------------------------
    assign w_eff_len  = (CNT_W+1)'(eff_len(32'(w_act_len), NUM_WORDS));
    assign w_last_idx = w_eff_len - (CNT_W+1)'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_act_load) begin
            r_cnt <= '0;
        end else if (w_act_shift) begin
            r_cnt <= r_cnt + (CNT_W+1)'(1);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                if (w_final && !w_hold_valid && !w_accept) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = w_hold_valid;
        if (r_state == STREAM) begin
            out_valid = 1'b1;
            out_last  = (r_cnt == w_last_idx);
            busy      = 1'b1;
        end
    end

    assign out_data = w_act_msb ? w_act_data[IN_WIDTH-1 -: OUT_WIDTH]
                                : w_act_data[OUT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_in_ready   <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_in_ready   <= ~w_hold_valid_next;
            r_frame_done <= w_final;
        end
    end

    assign in_ready   = r_in_ready;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
